trail_sram_arbiter: RTL and testbench

Owns the shared 16-bit asynchronous SRAM frame buffer. It sits directly downstream of the trail writer, queuing its single-cycle trail writes in a small FIFO, and serves VGA pixel reads during active video. Queued writes drain into SRAM only while the VGA controller reports blanking, so trail updates never disturb scan-out.

---
 rtl/trail_pkg.sv | 9 +
 rtl/trail_fifo.sv | 48 ++++
 rtl/trail_sram_arbiter.sv | 78 +++++++
 tb/tb_trail_sram_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/trail_pkg.sv
// trail_pkg: shared widths, SRAM FSM states and address helper for the trail frame buffer
package trail_pkg;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {READ, SETUP, WRITE, HOLD} sram_state_t;
    function automatic logic [ADDR_W-1:0] zext(input logic [18:0] a);
        return {{(ADDR_W-19){1'b0}}, a};
    endfunction
endpackage

// File: rtl/trail_fifo.sv
// trail_fifo: synchronous FIFO with flush and a tail-overwrite port for write coalescing
module trail_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 36,
    parameter int KW = 20
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       ovw,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [W-1:0]               next,
    output logic [KW-1:0]              tail_key,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [W-1:0] tail;
    logic pop_ok;
    assign pop_ok = pop && !empty;
    always_ff @(posedge Clk)
        if (Reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop_ok);
        end
    always_ff @(posedge Clk)
        if (!flush) begin
            if (push) mem[wr_ptr] <= din;
            else if (ovw) mem[wr_ptr - PW'(1)] <= din;
        end
    assign head = mem[rd_ptr];
    assign next = mem[rd_ptr + PW'(1)];
    assign tail = mem[wr_ptr - PW'(1)];
    assign tail_key = tail[W-1:W-KW];
    assign empty = count == '0;
    assign full = count == (PW+1)'(DEPTH);
endmodule

// File: rtl/trail_sram_arbiter.sv
// trail_sram_arbiter: queues trail writes and drains them into the shared SRAM during VGA blanking
module trail_sram_arbiter #(
    parameter int DEPTH = 8,
    parameter int ADDR_W = trail_pkg::ADDR_W,
    parameter int DATA_W = trail_pkg::DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [18:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              vga_blank,
    input  logic [ADDR_W-1:0] vga_rd_addr,
    output logic [DATA_W-1:0] vga_rd_data,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              full,
    output logic              overflow
);
    import trail_pkg::*;
    localparam int W = ADDR_W + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;
    sram_state_t state, nxt;
    logic [CW-1:0] count;
    logic empty, push, pop, ovw, coalesce, in_flight, fwd, go;
    logic [W-1:0] head, next_e, din, src;
    logic [ADDR_W-1:0] tail_key, wr_addr_ext, w_addr;
    logic [DATA_W-1:0] w_data;
    assign wr_addr_ext = ADDR_W'(zext(wr_addr));
    assign din = {wr_addr_ext, wr_data};
    assign pop = state == HOLD;
    assign in_flight = count == CW'(1) && state != READ;
    assign coalesce = wr_en && !empty && tail_key == wr_addr_ext && !in_flight;
    assign ovw = coalesce && !flush;
    assign push = wr_en && !coalesce && (!full || pop) && !flush;
    assign go = vga_blank && !flush;
    trail_fifo #(.DEPTH(DEPTH), .W(W), .KW(ADDR_W)) u_fifo (
        .Clk(Clk), .Reset(Reset), .flush(flush), .push(push), .pop(pop), .ovw(ovw),
        .din(din), .head(head), .next(next_e), .tail_key(tail_key),
        .count(count), .full(full), .empty(empty)
    );
    always_comb begin
        nxt = state == READ ? (go && !empty ? SETUP : READ) :
              state == SETUP ? WRITE :
              state == WRITE ? HOLD :
              (go && count > CW'(1) ? SETUP : READ);
    end
    // a coalesce landing on the entry being latched this edge must be forwarded
    assign fwd = ovw && count == (state == HOLD ? CW'(2) : CW'(1));
    assign src = fwd ? din : state == HOLD ? next_e : head;
    always_ff @(posedge Clk)
        if (Reset) begin
            state <= READ;
            w_addr <= '0;
            w_data <= '0;
            vga_rd_data <= '0;
            overflow <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt == SETUP) {w_addr, w_data} <= src;
            if (state == READ) vga_rd_data <= SRAM_DQ;
            if (flush) overflow <= 1'b0;
            else if (wr_en && !coalesce && full && !pop) overflow <= 1'b1;
        end
    assign SRAM_ADDR = state == READ ? vga_rd_addr : w_addr;
    assign SRAM_DQ = state != READ ? w_data : 'z;
    assign SRAM_OE_N = state != READ;
    assign SRAM_WE_N = state != WRITE;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
endmodule

// File: tb/tb_trail_sram_arbiter.sv
// tb_trail_sram_arbiter: directed vectors against hand-computed SRAM write traces
module tb_trail_sram_arbiter;
    logic Clk = 0, Reset = 1, flush = 0, wr_en = 0, vga_blank = 0;
    logic [18:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [19:0] vga_rd_addr = '0;
    logic [15:0] vga_rd_data;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, full, overflow;
    int tests = 0, fails = 0, we_cnt = 0;
    logic [35:0] wq[$];

    trail_sram_arbiter dut (
        .Clk(Clk), .Reset(Reset), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .vga_blank(vga_blank), .vga_rd_addr(vga_rd_addr),
        .vga_rd_data(vga_rd_data), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .full(full), .overflow(overflow)
    );

    always #10 Clk = ~Clk;

    function automatic logic [15:0] model(input logic [19:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    assign SRAM_DQ = !SRAM_OE_N ? model(SRAM_ADDR) : 'z;

    always @(negedge Clk)
        if (!SRAM_WE_N) begin
            wq.push_back({SRAM_ADDR, SRAM_DQ});
            we_cnt++;
        end

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wr(input logic [18:0] a, input logic [15:0] d);
        wr_en = 1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 0;
    endtask

    task automatic clr();
        wq.delete();
        we_cnt = 0;
    endtask

    function automatic logic [35:0] wq_at(input int i);
        return i < wq.size() ? wq[i] : 36'hF_FFFF_FFFF;
    endfunction

    initial begin
        step(2);
        check("rst state", 36'(dut.state), 36'd0);
        check("rst we_n", 36'(SRAM_WE_N), 36'd1);
        check("rst oe_n", 36'(SRAM_OE_N), 36'd0);
        check("rst ce/ub/lb", 36'({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}), 36'd0);
        check("rst full/ovf", 36'({full, overflow}), 36'd0);
        check("rst rd_data", 36'(vga_rd_data), 36'd0);
        check("rst count", 36'(dut.count), 36'd0);
        Reset = 0;
        vga_rd_addr = 20'h00123;
        step();
        check("read lat", 36'(vga_rd_data), 36'(16'h0123 ^ 16'h5A5A));
        vga_rd_addr = 20'h00456;
        step();
        check("read track", 36'(vga_rd_data), 36'(16'h0456 ^ 16'h5A5A));
        // basic write
        clr();
        wr(19'h00A40, 16'h0F0F);
        check("basic count", 36'(dut.count), 36'd1);
        vga_blank = 1;
        step();
        check("basic setup st", 36'(dut.state), 36'd1);
        check("basic setup addr", 36'(SRAM_ADDR), 36'h00A40);
        check("basic setup oe_n", 36'(SRAM_OE_N), 36'd1);
        step();
        check("basic we_n low", 36'(SRAM_WE_N), 36'd0);
        step();
        check("basic hold we_n", 36'(SRAM_WE_N), 36'd1);
        step();
        check("basic back read", 36'(dut.state), 36'd0);
        step(2);
        vga_blank = 0;
        check("basic we pulses", 36'(we_cnt), 36'd1);
        check("basic word", wq_at(0), 36'h00A40_0F0F);
        // coalesce
        clr();
        for (int i = 1; i <= 5; i++) wr(19'h01000, 16'(i));
        check("coal count", 36'(dut.count), 36'd1);
        vga_blank = 1;
        step(5);
        vga_blank = 0;
        check("coal we pulses", 36'(we_cnt), 36'd1);
        check("coal word", wq_at(0), 36'h01000_0005);
        // overflow
        clr();
        for (int i = 0; i < 8; i++) wr(19'h00200 + 19'(i), 16'h0100 + 16'(i));
        check("ovf full@8", 36'({full, overflow}), 36'b10);
        wr(19'h00208, 16'h0108);
        check("ovf flag@9", 36'({full, overflow}), 36'b11);
        check("ovf count", 36'(dut.count), 36'd8);
        vga_blank = 1;
        step(26);
        vga_blank = 0;
        check("ovf we pulses", 36'(we_cnt), 36'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("ovf word%0d", i), wq_at(i), {20'h00200 + 20'(i), 16'h0100 + 16'(i)});
        check("ovf drained", 36'({full, overflow, dut.count}), {32'd0, 1'b0, 1'b1, 4'd0} >> 0);
        // blank ends mid-drain
        clr();
        for (int i = 0; i < 4; i++) wr(19'h00300 + 19'(i), 16'h0300 + 16'(i));
        vga_blank = 1;
        step(5);
        vga_blank = 0;
        step(5);
        check("mid we pulses", 36'(we_cnt), 36'd2);
        check("mid word0", wq_at(0), 36'h00300_0300);
        check("mid word1", wq_at(1), 36'h00301_0301);
        check("mid count", 36'(dut.count), 36'd2);
        check("mid state", 36'(dut.state), 36'd0);
        vga_rd_addr = 20'h00777;
        step();
        check("mid read", 36'(vga_rd_data), 36'(16'h0777 ^ 16'h5A5A));
        check("ovf sticky", 36'(overflow), 36'd1);
        flush = 1;
        wr(19'h00999, 16'h9999);
        flush = 0;
        check("flush+wr count", 36'(dut.count), 36'd0);
        check("flush clr ovf", 36'(overflow), 36'd0);
        // flush during WRITE
        clr();
        for (int i = 0; i < 3; i++) wr(19'h00400 + 19'(i), 16'h0400 + 16'(i));
        vga_blank = 1;
        step(2);
        check("flush in write", 36'(dut.state), 36'd2);
        flush = 1;
        step();
        flush = 0;
        check("flush count", 36'(dut.count), 36'd0);
        step(6);
        vga_blank = 0;
        check("flush we pulses", 36'(we_cnt), 36'd1);
        check("flush word", wq_at(0), 36'h00400_0400);
        // reset mid-drain
        for (int i = 0; i < 3; i++) wr(19'h00500 + 19'(i), 16'h0500 + 16'(i));
        vga_blank = 1;
        step(2);
        Reset = 1;
        step();
        check("mrst state", 36'(dut.state), 36'd0);
        check("mrst we/oe", 36'({SRAM_WE_N, SRAM_OE_N}), 36'b10);
        check("mrst count", 36'(dut.count), 36'd0);
        check("mrst ovf", 36'(overflow), 36'd0);
        Reset = 0;
        vga_blank = 0;
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
